// File: rtl/ahb_matrix_output_arb_if.sv
// rtl/ahb_matrix_output_arb_if.sv - request/grant bundle between the input stages and one output-stage arbiter
interface ahb_matrix_output_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = 2
);
  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic [1:0]           sel_trans;
  logic [2:0]           sel_burst;
  logic                 sel_lock;
  logic [PW-1:0]        addr_in_port;
  logic                 no_port;
  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        data_in_port;
  logic                 data_no_port;
  logic                 burst_hold;

  modport slave (
    input  req_port, HREADYM, sel_trans, sel_burst, sel_lock,
    output addr_in_port, no_port, gnt, data_in_port, data_no_port, burst_hold
  );

  modport master (
    output req_port, HREADYM, sel_trans, sel_burst, sel_lock,
    input  addr_in_port, no_port, gnt, data_in_port, data_no_port, burst_hold
  );
endinterface

// File: rtl/ahb_matrix_output_arb.sv
// rtl/ahb_matrix_output_arb.sv - round-robin address/data-phase owner arbiter for one bus-matrix output stage
module ahb_matrix_output_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_matrix_output_arb_if.slave bus
);
  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0]    BURST_INCR = 3'b001;
  localparam int            PAD        = 2**PW;
  localparam logic [PW:0]   NP_EXT     = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS-1);

  logic [PW-1:0]  r_addr_in_port;
  logic [PW-1:0]  r_data_in_port;
  logic [PW-1:0]  r_last_grant;
  logic           r_no_port;
  logic           r_data_no_port;
  logic           r_burst_hold;
  logic [3:0]     r_beats_left;

  logic [3:0]     w_beats_next;
  logic           w_hold;
  logic [PAD-1:0] w_req_pad;
  logic [PAD-1:0] w_gnt_pad;
  logic [PW:0]    w_sum;
  logic [PW-1:0]  w_win;
  logic           w_found;

  // Remaining SEQ beats after the transfer currently on the output bus is accepted.
  always_comb begin
    w_beats_next = r_beats_left;
    case (bus.sel_trans)
      TR_NONSEQ: begin
        case (bus.sel_burst)
          3'b010, 3'b011: w_beats_next = 4'd3;
          3'b100, 3'b101: w_beats_next = 4'd7;
          3'b110, 3'b111: w_beats_next = 4'd15;
          default:        w_beats_next = 4'd0;
        endcase
      end
      TR_SEQ:  if (r_beats_left != 4'd0) w_beats_next = r_beats_left - 4'd1;
      TR_IDLE: w_beats_next = 4'd0;
      default: w_beats_next = r_beats_left;
    endcase
  end

  assign w_hold = !r_no_port &&
                  (bus.sel_lock ||
                   (bus.sel_trans == TR_BUSY) ||
                   (w_beats_next != 4'd0) ||
                   ((bus.sel_burst == BURST_INCR) && bus.sel_trans[1]));

  assign w_req_pad = PAD'(bus.req_port);

  // Cyclic scan starting just after the last winner; the last winner itself is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_grant;
    w_sum   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_sum = {1'b0, r_last_grant} + (PW+1)'(k);
      if (w_sum >= NP_EXT) w_sum = w_sum - NP_EXT;
      if (!w_found && w_req_pad[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_in_port <= '0;
      r_data_in_port <= '0;
      r_last_grant   <= LAST_PORT;
      r_no_port      <= 1'b1;
      r_data_no_port <= 1'b1;
      r_burst_hold   <= 1'b0;
      r_beats_left   <= 4'd0;
    end else if (bus.HREADYM) begin
      r_data_in_port <= r_addr_in_port;
      r_data_no_port <= r_no_port;
      r_burst_hold   <= w_hold;
      if (!r_no_port) r_beats_left <= w_beats_next;
      if (!w_hold) begin
        if (w_found) begin
          r_addr_in_port <= w_win;
          r_last_grant   <= w_win;
          r_no_port      <= 1'b0;
        end else begin
          r_no_port      <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gnt_pad = '0;
    if (!r_no_port) w_gnt_pad[r_addr_in_port] = 1'b1;
  end

  assign bus.gnt          = w_gnt_pad[NUM_PORTS-1:0];
  assign bus.addr_in_port = r_addr_in_port;
  assign bus.no_port      = r_no_port;
  assign bus.data_in_port = r_data_in_port;
  assign bus.data_no_port = r_data_no_port;
  assign bus.burst_hold   = r_burst_hold;
endmodule

// File: tb/tb_ahb_matrix_output_arb.sv
// tb/tb_ahb_matrix_output_arb.sv - scoreboard bench: per-port transfer queues and a transfer-level owner model
module tb_ahb_matrix_output_arb;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_matrix_output_arb_if #(.NUM_PORTS(NP), .PW(PW)) bus ();
  ahb_matrix_output_arb #(.NUM_PORTS(NP), .PW(PW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  // Beat encoding: {lock, burst[2:0], trans[1:0]}
  logic [5:0]  jobq [NP][$];
  logic [10:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  int         m_owner, m_dport, m_last, m_issued, m_blen;
  bit         m_no, m_dno, m_hold;
  logic [NP-1:0] cur_req;
  logic [5:0] cur_beat;
  bit         cur_rdy;

  function automatic int blen_of(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [5:0] bt(input logic l, input logic [2:0] b, input logic [1:0] t);
    return {l, b, t};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [3:0] g;
    g = m_no ? 4'b0000 : 4'(1 << m_owner);
    return {2'(m_owner), m_no, g, 2'(m_dport), m_dno, m_hold};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_dport = 0; m_last = NP - 1;
    m_no = 1'b1; m_dno = 1'b1; m_hold = 1'b0;
    m_issued = 0; m_blen = 0;
    for (int p = 0; p < NP; p++) jobq[p].delete();
  endtask

  task automatic add_single(input int p);
    jobq[p].push_back(bt(1'b0, 3'b000, T_NSEQ));
  endtask

  // beats = NONSEQ+SEQ count; an IDLE terminates INCR and any burst cut short
  task automatic add_burst(input int p, input logic [2:0] b, input int beats, input int busy_after);
    jobq[p].push_back(bt(1'b0, b, T_NSEQ));
    for (int i = 1; i < beats; i++) begin
      if (i == busy_after) jobq[p].push_back(bt(1'b0, b, T_BUSY));
      jobq[p].push_back(bt(1'b0, b, T_SEQ));
    end
    if (b == 3'b001 || beats < blen_of(b)) jobq[p].push_back(bt(1'b0, 3'b000, T_IDLE));
  endtask

  task automatic add_locked(input int p);
    jobq[p].push_back(bt(1'b1, 3'b000, T_NSEQ));
    jobq[p].push_back(bt(1'b1, 3'b000, T_IDLE));
    jobq[p].push_back(bt(1'b1, 3'b000, T_NSEQ));
    jobq[p].push_back(bt(1'b0, 3'b000, T_IDLE));
  endtask

  // One accepted HREADYM edge: owner's presented transfer retires, then ownership is decided.
  task automatic model_step();
    bit h;
    int p;
    if (!cur_rdy) return;
    h = 1'b0;
    m_dport = m_owner;
    m_dno   = m_no;
    if (!m_no) begin
      if (jobq[m_owner].size() > 0) void'(jobq[m_owner].pop_front());
      case (cur_beat[1:0])
        T_NSEQ: begin m_issued = 1; m_blen = blen_of(cur_beat[4:2]); end
        T_SEQ:  m_issued++;
        T_IDLE: begin m_issued = 0; m_blen = 0; end
        default: ;
      endcase
      h = cur_beat[5] || (cur_beat[1:0] == T_BUSY) || (m_issued < m_blen) ||
          ((cur_beat[4:2] == 3'b001) && cur_beat[1]);
    end
    m_hold = h;
    if (!h) begin
      m_no = 1'b1;
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (cur_req[p]) begin
          m_owner = p; m_last = p; m_no = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic drive(input bit rdy);
    cur_rdy = rdy;
    for (int p = 0; p < NP; p++) cur_req[p] = (jobq[p].size() > 0);
    cur_beat = 6'b000000;
    if (!m_no && jobq[m_owner].size() > 0) cur_beat = jobq[m_owner][0];
    bus.req_port  = cur_req;
    bus.HREADYM   = rdy;
    bus.sel_trans = cur_beat[1:0];
    bus.sel_burst = cur_beat[4:2];
    bus.sel_lock  = cur_beat[5];
  endtask

  task automatic drive_quiet();
    bus.req_port  = '0;
    bus.HREADYM   = 1'b0;
    bus.sel_trans = T_IDLE;
    bus.sel_burst = 3'b000;
    bus.sel_lock  = 1'b0;
  endtask

  task automatic cycle(input bit rdy);
    drive(rdy);
    @(posedge HCLK);
    model_step();
    exp_q.push_back(exp_vec());
    #1;
  endtask

  // Entered 1 unit after an edge: the pending sample becomes a reset-value check before any clock edge.
  task automatic do_reset();
    HRESETn = 1'b0;
    drive_quiet();
    model_reset();
    void'(exp_q.pop_back());
    exp_q.push_back(exp_vec());
    @(posedge HCLK);
    exp_q.push_back(exp_vec());
    #1 HRESETn = 1'b1;
  endtask

  initial begin
    logic [10:0] e, a;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.addr_in_port, bus.no_port, bus.gnt, bus.data_in_port, bus.data_no_port, bus.burst_hold};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL owner_outputs t=%0t actual addr=%0d no=%b gnt=%b dport=%0d dno=%b hold=%b required addr=%0d no=%b gnt=%b dport=%0d dno=%b hold=%b",
                   $time, a[10:9], a[8], a[7:4], a[3:2], a[1], a[0],
                   e[10:9], e[8], e[7:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout t=%0t actual stimulus_done=%b required stimulus_done=1", $time, done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    int p;
    logic [2:0] b;
    logic [10:0] r;
    drive_quiet();
    model_reset();
    HRESETn = 1'b0;
    repeat (2) begin
      @(posedge HCLK);
      exp_q.push_back(exp_vec());
    end
    #1;
    r = {bus.addr_in_port, bus.no_port, bus.gnt, bus.data_in_port, bus.data_no_port, bus.burst_hold};
    n_cmp++;
    if (r !== 11'b00_1_0000_00_1_0) begin
      n_err++;
      $display("FAIL reset_state t=%0t actual addr=%0d no=%b gnt=%b dport=%0d dno=%b hold=%b required addr=0 no=1 gnt=0000 dport=0 dno=1 hold=0",
               $time, r[10:9], r[8], r[7:4], r[3:2], r[1], r[0]);
    end
    HRESETn = 1'b1;

    add_single(0);
    repeat (4) cycle(1'b1);

    for (int q = 0; q < NP; q++) begin add_single(q); add_single(q); end
    repeat (12) cycle(1'b1);

    add_burst(1, 3'b011, 4, 0);
    add_single(0); add_single(2); add_single(3);
    repeat (14) cycle(1'b1);

    add_burst(2, 3'b101, 8, 3);
    add_single(3); add_single(0);
    for (int i = 0; i < 18; i++) cycle(!(i == 6 || i == 7));

    add_locked(3);
    add_single(0); add_single(1);
    repeat (12) cycle(1'b1);

    add_burst(0, 3'b111, 5, 0);
    add_single(1);
    repeat (10) cycle(1'b1);

    add_burst(0, 3'b110, 16, 0);
    add_single(2);
    repeat (6) cycle(1'b1);
    do_reset();
    repeat (3) cycle(1'b1);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        p = int'($urandom_range(0, NP - 1));
        if (jobq[p].size() < 8) begin
          case ($urandom_range(0, 3))
            0: add_single(p);
            1: begin
              b = 3'($urandom_range(2, 7));
              add_burst(p, b, int'($urandom_range(1, blen_of(b))), int'($urandom_range(0, 4)));
            end
            2: add_burst(p, 3'b001, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
            default: add_locked(p);
          endcase
        end
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0);
    end

    @(negedge HCLK);
    #1;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
